// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles everything the data-memory arbiter talks to except clock and reset:
//   a_*   : port A (CPU core) request, ready pulse and read data
//   b_*   : port B (loader/debug) request, ready pulse and read data
//   mem_* : single-port data memory; mem_reg is both read and write address,
//           mem_read_data is combinational from the memory
//   grant_b : which port owns the access in flight (debug visibility)
// The slave modport is the arbiter's view; the master modport is the view of
// the environment (requesters plus memory).

interface dmem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_write;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_write_data;
    logic              a_ready;
    logic [DATA_W-1:0] a_read_data;

    logic              b_req;
    logic              b_write;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_write_data;
    logic              b_ready;
    logic [DATA_W-1:0] b_read_data;

    logic              mem_write;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    logic              grant_b;

    modport slave (
        input  a_req, a_write, a_reg, a_write_data,
        output a_ready, a_read_data,
        input  b_req, b_write, b_reg, b_write_data,
        output b_ready, b_read_data,
        output mem_write, mem_reg, mem_write_data,
        input  mem_read_data,
        output grant_b
    );

    modport master (
        output a_req, a_write, a_reg, a_write_data,
        input  a_ready, a_read_data,
        output b_req, b_write, b_reg, b_write_data,
        input  b_ready, b_read_data,
        input  mem_write, mem_reg, mem_write_data,
        output mem_read_data,
        input  grant_b
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Round-robin arbiter letting two requesters share one single-port data
// memory. Every access walks IDLE -> SERVE -> RESP, so one access completes
// every three cycles. Requests are sampled only in IDLE; the winner's
// write/reg/write_data are latched there and replayed to the memory in SERVE.
// Read data is captured for reads and writes alike at the end of SERVE.
//
// Ports:
//   clk   - single clock, all state changes on the rising edge
//   reset - synchronous, active-high; aborts any access in flight
//   bus   - dmem_arbiter_if.slave (both requester ports, memory side, grant_b)
//
// state | meaning
// IDLE  | wait for a request; pick winner, latch its access
// SERVE | latched access driven to memory; read data captured at exit
// RESP  | winner's ready high for this one cycle

module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              last_b_q,    last_b_d;
    logic              grant_b_q,   grant_b_d;
    logic              lat_write_q, lat_write_d;
    logic [ADDR_W-1:0] lat_reg_q,   lat_reg_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0] a_rdata_q,   a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q,   b_rdata_d;
    logic              a_ready_q,   a_ready_d;
    logic              b_ready_q,   b_ready_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            // Pretend B was granted last so A wins the first conflict.
            last_b_q    <= 1'b1;
            grant_b_q   <= 1'b0;
            lat_write_q <= 1'b0;
            lat_reg_q   <= '0;
            lat_wdata_q <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            a_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            grant_b_q   <= grant_b_d;
            lat_write_q <= lat_write_d;
            lat_reg_q   <= lat_reg_d;
            lat_wdata_q <= lat_wdata_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            a_ready_q   <= a_ready_d;
            b_ready_q   <= b_ready_d;
        end
    end

    always_comb begin
        logic win_b;

        state_d     = state_q;
        last_b_d    = last_b_q;
        grant_b_d   = grant_b_q;
        lat_write_d = lat_write_q;
        lat_reg_d   = lat_reg_q;
        lat_wdata_d = lat_wdata_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_ready_d   = 1'b0;
        b_ready_d   = 1'b0;
        win_b       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    // B wins alone, or in a conflict when A was granted last.
                    win_b       = bus.b_req && (!bus.a_req || !last_b_q);
                    grant_b_d   = win_b;
                    last_b_d    = win_b;
                    lat_write_d = win_b ? bus.b_write      : bus.a_write;
                    lat_reg_d   = win_b ? bus.b_reg        : bus.a_reg;
                    lat_wdata_d = win_b ? bus.b_write_data : bus.a_write_data;
                    state_d     = SERVE;
                end
            end
            SERVE: begin
                // For a write this captures the word being overwritten.
                if (grant_b_q) begin
                    b_rdata_d = bus.mem_read_data;
                end else begin
                    a_rdata_d = bus.mem_read_data;
                end
                a_ready_d = !grant_b_q;
                b_ready_d = grant_b_q;
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset is synchronous, so a reset arriving during SERVE would otherwise
    // still commit the write at the very edge that aborts the access.
    assign bus.mem_write      = (state_q == SERVE) && lat_write_q && !reset;
    assign bus.mem_reg        = lat_reg_q;
    assign bus.mem_write_data = lat_wdata_q;
    assign bus.a_ready        = a_ready_q;
    assign bus.b_ready        = b_ready_q;
    assign bus.a_read_data    = a_rdata_q;
    assign bus.b_read_data    = b_rdata_q;
    assign bus.grant_b        = grant_b_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Drives both requester ports, provides the data memory, and compares the
// arbiter against a transaction-level reference model every cycle, plus a
// set of directed scenarios with hand-computed expectations.

module tb_dmem_arbiter;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory: combinational read, write on the rising edge.
    logic [DATA_W-1:0] mem [DEPTH];
    assign bus.mem_read_data = mem[bus.mem_reg];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.mem_write) begin
            mem[bus.mem_reg] <= bus.mem_write_data;
        end
    end

    // Reference model: one access at a time, occupying three cycles
    // (m_phase 0 = free, 1 = being served, 2 = answering).
    int                m_phase;
    bit                m_last_b;
    bit                m_win_b;
    bit                m_wr;
    logic [ADDR_W-1:0] m_reg;
    logic [DATA_W-1:0] m_wd;
    logic [DATA_W-1:0] m_a_rd;
    logic [DATA_W-1:0] m_b_rd;
    logic [DATA_W-1:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end
        if (reset) begin
            m_phase  = 0;
            m_last_b = 1'b1;
            m_win_b  = 1'b0;
            m_wr     = 1'b0;
            m_reg    = '0;
            m_wd     = '0;
            m_a_rd   = '0;
            m_b_rd   = '0;
        end else if (m_phase == 0) begin
            if (bus.a_req || bus.b_req) begin
                if (bus.a_req && bus.b_req) m_win_b = !m_last_b;
                else                        m_win_b = bus.b_req;
                m_last_b = m_win_b;
                m_wr     = m_win_b ? bus.b_write      : bus.a_write;
                m_reg    = m_win_b ? bus.b_reg        : bus.a_reg;
                m_wd     = m_win_b ? bus.b_write_data : bus.a_write_data;
                m_phase  = 1;
            end
        end else if (m_phase == 1) begin
            if (m_win_b) m_b_rd = ref_mem[m_reg];
            else         m_a_rd = ref_mem[m_reg];
            if (m_wr) ref_mem[m_reg] = m_wd;
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_write",      bus.mem_write, (m_phase == 1) && m_wr && !reset);
            check("mem_reg",        bus.mem_reg, m_reg);
            check("mem_write_data", bus.mem_write_data, m_wd);
            check("a_ready",        bus.a_ready, (m_phase == 2) && !m_win_b);
            check("b_ready",        bus.b_ready, (m_phase == 2) && m_win_b);
            check("a_read_data",    bus.a_read_data, m_a_rd);
            check("b_read_data",    bus.b_read_data, m_b_rd);
            check("grant_b",        bus.grant_b, m_win_b);
            check("mem_content",    mem[m_reg], ref_mem[m_reg]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit pb, input bit rq, input bit wr,
                         input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        if (pb) begin
            bus.b_req = rq; bus.b_write = wr; bus.b_reg = r; bus.b_write_data = d;
        end else begin
            bus.a_req = rq; bus.a_write = wr; bus.a_reg = r; bus.a_write_data = d;
        end
    endtask

    function automatic logic rdy(input bit pb);
        return pb ? bus.b_ready : bus.a_ready;
    endfunction

    function automatic logic [DATA_W-1:0] rdat(input bit pb);
        return pb ? bus.b_read_data : bus.a_read_data;
    endfunction

    // One access on one port; returns read data at ready, the number of
    // edges from presenting req to seeing ready, and mem_write cycles seen.
    // Ends in the IDLE cycle after RESP with req dropped.
    task automatic access(input bit pb, input bit wr, input logic [ADDR_W-1:0] r,
                          input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] rd,
                          output int lat, output int mw);
        drive(pb, 1'b1, wr, r, d);
        lat = 0;
        mw  = 0;
        do begin
            tick();
            lat++;
            if (bus.mem_write) mw++;
        end while (!rdy(pb) && lat < 10);
        rd = rdat(pb);
        drive(pb, 1'b0, 1'b0, r, d);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_port(input bit pb);
        logic rq;
        rq = pb ? bus.b_req : bus.a_req;
        if (rq && rdy(pb)) begin
            if ($urandom_range(1, 0) == 0) drive(pb, 1'b0, 1'b0, '0, '0);
            else drive(pb, 1'b1, 1'($urandom_range(1, 0)), ADDR_W'($urandom_range(7, 0)),
                       DATA_W'($urandom));
        end else if (!rq) begin
            if ($urandom_range(99, 0) < 40)
                drive(pb, 1'b1, 1'($urandom_range(1, 0)), ADDR_W'($urandom_range(7, 0)),
                      DATA_W'($urandom));
        end else if ($urandom_range(99, 0) < 15) begin
            // Scribble on a pending request; occasionally withdraw it.
            drive(pb, 1'($urandom_range(99, 0) < 90), 1'($urandom_range(1, 0)),
                  ADDR_W'($urandom_range(7, 0)), DATA_W'($urandom));
        end
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        int lat;
        int mw;
        int ta;
        int tb;
        logic [DATA_W-1:0] a_val;
        int ev_port [6];
        int ev_time [6];
        int n_ev;

        reset = 1'b1;
        mem_clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mem_clear = 1'b0;
        chk_en = 1'b1;

        // Reset state.
        check("rst_a_ready", bus.a_ready, 0);
        check("rst_b_ready", bus.b_ready, 0);
        check("rst_a_read_data", bus.a_read_data, 0);
        check("rst_b_read_data", bus.b_read_data, 0);
        check("rst_mem_reg", bus.mem_reg, 0);
        check("rst_mem_write_data", bus.mem_write_data, 0);
        check("rst_grant_b", bus.grant_b, 0);
        check("rst_mem_write", bus.mem_write, 0);

        // Write then read back on port A.
        access(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, rd, lat, mw);
        check("wr5_latency", lat, 2);
        check("wr5_mem_write_cycles", mw, 1);
        access(1'b0, 1'b0, 6'd5, 32'h0, rd, lat, mw);
        check("rd5_data", rd, 32'hDEADBEEF);
        check("rd5_mem_write_cycles", mw, 0);

        // First conflict after reset: A (read reg 1) beats B (write reg 1).
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 6'd1, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 6'd1, 32'h12345678);
        ta = -1;
        tb = -1;
        a_val = '0;
        for (int c = 1; c <= 12 && (ta < 0 || tb < 0); c++) begin
            tick();
            if (bus.a_ready && ta < 0) begin
                ta = c;
                a_val = bus.a_read_data;
                bus.a_req = 1'b0;
            end
            if (bus.b_ready && tb < 0) begin
                tb = c;
                bus.b_req = 1'b0;
            end
        end
        check("conflict_a_time", ta, 2);
        check("conflict_b_time", tb, 5);
        check("conflict_a_old_data", a_val, 32'h0);
        tick();
        access(1'b0, 1'b0, 6'd1, 32'h0, rd, lat, mw);
        check("conflict_readback", rd, 32'h12345678);

        // Single B read: ready in the RESP cycle, two edges after req is
        // presented (request cycle, SERVE, RESP); A's data untouched.
        access(1'b1, 1'b0, 6'd5, 32'h0, rd, lat, mw);
        check("b_read_latency", lat, 2);
        check("b_read_data", rd, 32'hDEADBEEF);
        check("b_read_a_data_kept", bus.a_read_data, 32'h12345678);

        // Inputs scribbled during SERVE/RESP are ignored.
        drive(1'b0, 1'b1, 1'b1, 6'd3, 32'hA5A50003);
        tick();
        drive(1'b0, 1'b1, 1'b0, 6'd7, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 6'd4, 32'h44444444);
        check("ign_serve_mem_write", bus.mem_write, 1);
        check("ign_serve_mem_reg", bus.mem_reg, 3);
        check("ign_serve_wdata", bus.mem_write_data, 32'hA5A50003);
        tick();
        check("ign_resp_a_ready", bus.a_ready, 1);
        check("ign_resp_mem_reg", bus.mem_reg, 3);
        drive(1'b0, 1'b0, 1'b1, 6'd2, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 6'd4, 32'h0);
        tick();
        check("ign_idle_mem_reg_hold", bus.mem_reg, 3);
        check("ign_idle_wdata_hold", bus.mem_write_data, 32'hA5A50003);
        check("ign_mem3", mem[3], 32'hA5A50003);
        check("ign_mem4_untouched", mem[4], 32'h0);

        // Reset during SERVE of a B write aborts it.
        access(1'b0, 1'b1, 6'd9, 32'h11110009, rd, lat, mw);
        drive(1'b1, 1'b1, 1'b1, 6'd9, 32'hCAFEF00D);
        tick();
        check("abort_serve_mem_write", bus.mem_write, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
        check("abort_mem_write", bus.mem_write, 0);
        check("abort_b_ready", bus.b_ready, 0);
        tick();
        check("abort_b_ready_later", bus.b_ready, 0);
        check("abort_mem9_kept", mem[9], 32'h11110009);
        access(1'b0, 1'b0, 6'd9, 32'h0, rd, lat, mw);
        check("abort_idle_latency", lat, 2);
        check("abort_readback", rd, 32'h11110009);

        // Both ports holding req continuously: strict alternation from A.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 6'd2, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 6'd3, 32'h0);
        n_ev = 0;
        for (int c = 1; c <= 40 && n_ev < 6; c++) begin
            tick();
            if (bus.a_ready || bus.b_ready) begin
                ev_port[n_ev] = bus.b_ready ? 1 : 0;
                ev_time[n_ev] = c;
                check("rr_grant_b", bus.grant_b, (n_ev % 2));
                n_ev++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        check("rr_events", n_ev, 6);
        for (int i = 0; i < n_ev; i++) begin
            check("rr_port", ev_port[i], i % 2);
            check("rr_time", ev_time[i], 2 + 3 * i);
        end
        tick();
        tick();

        // Random traffic against the model.
        for (int cyc = 0; cyc < 800; cyc++) begin
            rand_port(1'b0);
            rand_port(1'b1);
            reset = ($urandom_range(299, 0) == 0);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
